// File: rtl/ahb_spi_slave_if.sv
// AHB-Lite slave-side bus bundle for the SPI responder peripheral.
interface ahb_spi_slave_if;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;

    modport master (output HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA, input HRDATA);
    modport slave  (input HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA, output HRDATA);
endinterface

// File: rtl/ahb_spi_slave.sv
// AHB-Lite SPI mode-0 responder with TX holding, RX data and status registers.
// Optional feature macro: SPIS_IRQ_EN enables the IE bit and the registered IRQ output.
module ahb_spi_slave (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_spi_slave_if.slave  bus,
    input  logic            SCLK,
    input  logic            MOSI,
    input  logic            CS_N,
    output logic            MISO,
    output logic            IRQ
);
    logic [1:0] addr_p0;
    logic       wr_p0, rd_p0;
    logic       sclk_p0, sclk_p1, sclk_p2;
    logic       cs_p0, cs_p1, cs_p2;
    logic       mosi_p0, mosi_p1;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift, tx_hold, rx_data;
    logic       tx_empty, rx_valid, overrun, abort, cs_active, ie, irq, miso;

    function automatic logic [7:0] tx_next(input logic empty, input logic [7:0] hold);
        return empty ? 8'hFF : hold;
    endfunction

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;

    logic wr_status, wr_tx, rd_rx, tx_load, byte_done;
    logic [7:0] tx_load_val;
    assign wr_status   = wr_p0 && (addr_p0 == 2'd0);
    assign wr_tx       = wr_p0 && (addr_p0 == 2'd1);
    assign rd_rx       = rd_p0 && (addr_p0 == 2'd2);
    assign tx_load     = cs_fall | (cs_active & sclk_fall & (bit_cnt == 3'd0));
    assign byte_done   = ~cs_fall & ~cs_rise & cs_active & sclk_rise & (bit_cnt == 3'd7);
    assign tx_load_val = tx_next(tx_empty, tx_hold);

    logic unused_bits;
`ifdef SPIS_IRQ_EN
    assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA[31:9]};
`else
    assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA[31:8]};
`endif

    // Address phase capture and input synchronisers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_p0 <= 2'd0;
            wr_p0   <= 1'b0;
            rd_p0   <= 1'b0;
            sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1; cs_p1   <= 1'b1; cs_p2   <= 1'b1;
            mosi_p0 <= 1'b0; mosi_p1 <= 1'b0;
        end else begin
            if (bus.HREADY) begin
                addr_p0 <= bus.HADDR[3:2];
                wr_p0   <= bus.HSEL & bus.HWRITE & bus.HTRANS[1];
                rd_p0   <= bus.HSEL & ~bus.HWRITE & bus.HTRANS[1];
            end
            sclk_p0 <= SCLK;  sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
            cs_p0   <= CS_N;  cs_p1   <= cs_p0;   cs_p2   <= cs_p1;
            mosi_p0 <= MOSI;  mosi_p1 <= mosi_p0;
        end
    end

    // SPI frame engine and register side effects
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'd0;
            tx_shift  <= 8'd0;
            tx_hold   <= 8'd0;
            rx_data   <= 8'd0;
            tx_empty  <= 1'b1;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            abort     <= 1'b0;
            cs_active <= 1'b0;
            ie        <= 1'b0;
            irq       <= 1'b0;
            miso      <= 1'b0;
        end else begin
            if (cs_fall) begin
                bit_cnt   <= 3'd0;
                rx_shift  <= 8'd0;
                tx_shift  <= tx_load_val;
                miso      <= tx_load_val[7];
                cs_active <= 1'b1;
            end else if (cs_rise) begin
                bit_cnt   <= 3'd0;
                rx_shift  <= 8'd0;
                miso      <= 1'b0;
                cs_active <= 1'b0;
            end else if (cs_active) begin
                if (sclk_rise) begin
                    rx_shift[bit_cnt] <= mosi_p1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        rx_data <= {mosi_p1, rx_shift[6:0]};
                end else if (sclk_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_shift <= tx_load_val;
                        miso     <= tx_load_val[7];
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        miso     <= tx_shift[6];
                    end
                end
            end

            // A CPU write wins over a simultaneous load, which still takes the old value
            if (wr_tx) begin
                tx_hold  <= bus.HWDATA[7:0];
                tx_empty <= 1'b0;
            end else if (tx_load) begin
                tx_empty <= 1'b1;
            end

            if (byte_done)
                rx_valid <= 1'b1;
            else if (rd_rx)
                rx_valid <= 1'b0;

            if (byte_done && rx_valid && !rd_rx)
                overrun <= 1'b1;
            else if (wr_status && bus.HWDATA[2])
                overrun <= 1'b0;

            if (cs_rise && cs_active && (bit_cnt != 3'd0))
                abort <= 1'b1;
            else if (wr_status && bus.HWDATA[3])
                abort <= 1'b0;

`ifdef SPIS_IRQ_EN
            if (wr_status)
                ie <= bus.HWDATA[8];
            irq <= ie & (rx_valid | overrun | abort);
`else
            ie  <= 1'b0;
            irq <= 1'b0;
`endif
        end
    end

    always_comb begin
        bus.HRDATA = 32'd0;
        case (addr_p0)
            2'd0:    bus.HRDATA = {23'd0, ie, 3'd0, cs_active, abort, overrun, tx_empty, rx_valid};
            2'd1:    bus.HRDATA = {24'd0, tx_hold};
            2'd2:    bus.HRDATA = {24'd0, rx_data};
            default: bus.HRDATA = 32'd0;
        endcase
    end

    assign MISO = miso;
    assign IRQ  = irq;
endmodule

// File: tb/tb_ahb_spi_slave.sv
// Directed bench for ahb_spi_slave: AHB register accesses plus an SPI mode-0 master at HCLK/16.
module tb_ahb_spi_slave;
    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    logic SCLK = 1'b0, MOSI = 1'b0, CS_N = 1'b1;
    logic MISO, IRQ;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] rd;
    logic [7:0]  rx;

    ahb_spi_slave_if bus();

    ahb_spi_slave dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
        .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N), .MISO(MISO), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = addr;
        @(negedge HCLK);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge HCLK);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = addr;
        @(negedge HCLK);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        data = bus.HRDATA;
    endtask

    // Sends nbits of d LSB-first; MISO captured MSB-first into r at each rising SCLK.
    task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] r);
        r = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = d[i];
            idle(8);
            SCLK = 1'b1;
            r[7-i] = MISO;
            idle(8);
            SCLK = 1'b0;
        end
    endtask

    task automatic cs_low();
        CS_N = 1'b0;
        idle(8);
    endtask

    task automatic cs_high();
        idle(8);
        CS_N = 1'b1;
        idle(8);
    endtask

    initial begin
        bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HADDR = 32'd0;
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = 32'd0;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        check("reset_miso", {31'd0, MISO}, 32'd0);
        check("reset_irq", {31'd0, IRQ}, 32'd0);
        check("reset_hrdata", bus.HRDATA, 32'h2);
        ahb_read(32'h0, rd);
        check("reset_status", rd, 32'h2);

        // Single byte with loaded TX data
        ahb_write(32'h4, 32'hA5);
        ahb_read(32'h4, rd);
        check("txdata_readback", rd, 32'hA5);
        ahb_read(32'h0, rd);
        check("status_tx_full", rd, 32'h0);
        cs_low();
        spi_bits(8'h3C, 8, rx);
        check("miso_byte_a5", {24'd0, rx}, 32'hA5);
        idle(8);
        ahb_read(32'h0, rd);
        check("status_in_cs", rd, 32'h13);
        cs_high();
        check("miso_cs_high", {31'd0, MISO}, 32'd0);
        ahb_read(32'h0, rd);
        check("status_after_cs", rd, 32'h3);
        ahb_read(32'h8, rd);
        check("rxdata_3c", rd, 32'h3C);
        ahb_read(32'h0, rd);
        check("status_rx_cleared", rd, 32'h2);

        // Two bytes in one frame with TX underrun -> overrun, 0xFF on MISO
        cs_low();
        spi_bits(8'h11, 8, rx);
        check("underrun_byte0", {24'd0, rx}, 32'hFF);
        spi_bits(8'h22, 8, rx);
        check("underrun_byte1", {24'd0, rx}, 32'hFF);
        cs_high();
        ahb_read(32'h0, rd);
        check("status_overrun", rd, 32'h7);
        ahb_read(32'h8, rd);
        check("rxdata_22", rd, 32'h22);
        ahb_read(32'h0, rd);
        check("status_after_rd", rd, 32'h6);
        ahb_write(32'h0, 32'h4);
        ahb_read(32'h0, rd);
        check("status_w1c_ovr", rd, 32'h2);

        // Full byte left unread, then a 3-bit aborted frame
        cs_low();
        spi_bits(8'h77, 8, rx);
        cs_high();
        cs_low();
        spi_bits(8'h00, 3, rx);
        cs_high();
        ahb_read(32'h0, rd);
        check("status_abort", rd, 32'hB);
        ahb_read(32'h8, rd);
        check("rxdata_kept_77", rd, 32'h77);
        ahb_write(32'h0, 32'h8);
        ahb_read(32'h0, rd);
        check("status_w1c_abort", rd, 32'h2);
        ahb_write(32'h4, 32'hC3);
        cs_low();
        spi_bits(8'h5A, 8, rx);
        cs_high();
        check("miso_byte_c3", {24'd0, rx}, 32'hC3);
        ahb_read(32'h8, rd);
        check("rxdata_5a", rd, 32'h5A);
        ahb_read(32'hC, rd);
        check("reserved_reads_0", rd, 32'h0);

        // Interrupt behaviour
        ahb_write(32'h0, 32'h100);
        ahb_read(32'h0, rd);
`ifdef SPIS_IRQ_EN
        check("status_ie_set", rd, 32'h102);
        check("irq_idle", {31'd0, IRQ}, 32'd0);
        cs_low();
        spi_bits(8'h81, 8, rx);
        cs_high();
        check("irq_on_rx", {31'd0, IRQ}, 32'd1);
        ahb_read(32'h8, rd);
        check("rxdata_81", rd, 32'h81);
        @(negedge HCLK);
        check("irq_lag", {31'd0, IRQ}, 32'd1);
        @(negedge HCLK);
        check("irq_cleared", {31'd0, IRQ}, 32'd0);
`else
        check("status_ie_ignored", rd, 32'h2);
        cs_low();
        spi_bits(8'h81, 8, rx);
        cs_high();
        check("irq_tied_low", {31'd0, IRQ}, 32'd0);
        ahb_read(32'h8, rd);
        check("rxdata_81", rd, 32'h81);
        idle(2);
        check("irq_still_low", {31'd0, IRQ}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
